rainbow_pwm: RTL and testbench
==============================

RAINBOW_PWM -- requirements
Module: rainbow_pwm

Interface
REQ-001 SHALL provide parameter PWM_BITS, default 8, meaning PWM/ramp resolution; MAX = 2^PWM_BITS-1.
REQ-002 SHALL provide parameter STEP_DIV, default 1024, meaning clocks per hue ramp step (>=1).
REQ-003 SHALL provide parameter ACTIVE_LOW, default 1, meaning 1 = LED pin lit when 0 (Tang Nano RGB), 0 = lit when 1.
REQ-004 SHALL have exactly one clock and one reset: the reset is synchronous and active-low.
REQ-005 SHALL have port clk, input, 1, the single system clock.
REQ-006 SHALL have port rst_n, input, 1, the synchronous active-low reset.
REQ-007 SHALL have port mode, input, 2, selecting 00 rainbow, 01 static, 10 off, 11 freeze.
REQ-008 SHALL have port static_rgb, input, 3*PWM_BITS, the static colour {R,G,B}, R in the MSBs.
REQ-009 SHALL have port brightness, input, PWM_BITS, the global brightness scale.
REQ-010 SHALL have port led, output, 3, where bit0 = R, bit1 = G, bit2 = B.

Function
REQ-011 SHALL run a free-running pwm_cnt over 0..MAX-1 that wraps to 0 after MAX-1, giving a period of MAX clocks.
REQ-012 SHALL light a channel while pwm_cnt < duty_q: duty 0 is never lit, duty MAX is always lit.
REQ-013 SHALL load duty_q for all three channels only in the cycle pwm_cnt==MAX-1, so a new colour takes effect from the next period start and no mid-period glitch occurs.
REQ-014 SHALL produce led = lit XOR ACTIVE_LOW, registered (one-cycle latency from pwm_cnt/duty_q).
REQ-015 SHALL run a prescaler 0..STEP_DIV-1; its terminal count produces a step tick.
REQ-016 SHALL use a hue FSM with states P0..P5 plus an 8-bit-wide-or-larger ramp register 0..MAX.
REQ-017 SHALL, on a step tick in rainbow mode, increment ramp if ramp<MAX, otherwise set ramp=0 and advance the phase (P5 wraps to P0).
REQ-018 SHALL generate the rainbow colour as P0 (MAX,ramp,0), P1 (MAX-ramp,MAX,0), P2 (0,MAX,ramp), P3 (0,MAX-ramp,MAX), P4 (ramp,0,MAX), P5 (MAX,0,MAX-ramp).
REQ-019 SHALL, in mode 01, take the colour from static_rgb and hold hue, ramp and prescaler.
REQ-020 SHALL, in mode 10, use colour (0,0,0) and hold hue, ramp and prescaler.
REQ-021 SHALL, in mode 11, output the rainbow colour of the current phase/ramp while holding hue, ramp and prescaler; re-entering 00 resumes from the frozen point.
REQ-022 SHALL apply a mode change to duty_q at the next period boundary only, per REQ-013.
REQ-023 SHALL, when a step tick and a period boundary coincide, load duty_q from the pre-step colour; the stepped colour appears one period later.

Reset
REQ-024 SHALL, while rst_n is low at a clk edge, set pwm_cnt=0, prescaler=0, phase=P0, ramp=0, duty_q=0 and led=3'b111 if ACTIVE_LOW else 3'b000 (all dark).
REQ-025 SHALL give reset asserted mid-period or mid-ramp priority over every other update; the first period after release starts at pwm_cnt=0 with duty_q=0.

Configuration
REQ-026 SHALL, with macro RAINBOW_PWM_BRIGHTNESS_EN defined, compute per-channel duty = (c*(brightness+1))>>PWM_BITS, where the product is 2*PWM_BITS+1 bits wide, so brightness=MAX gives duty=c and brightness=0 gives duty=c>>PWM_BITS.
REQ-027 SHALL, without RAINBOW_PWM_BRIGHTNESS_EN, set duty = c, ignore brightness, and add no multiplier.

Verification (PWM_BITS=4, MAX=15, STEP_DIV=2, ACTIVE_LOW=1 unless noted)
REQ-028 SHALL cover: rst_n low for 3 clocks, mode=00 -> led=3'b111 throughout reset and for the first period after release.
REQ-029 SHALL cover: mode=01, static_rgb={4'd15,4'd0,4'd5}, macro off -> per 15-clock period, R pin low 15/15, G pin low 0/15, B pin low 5/15.
REQ-030 SHALL cover: mode=00 from reset -> phase advances P0->P1 after 16 step ticks (32 clocks); after 6*16*2=192 clocks it is back in P0 with ramp=0.
REQ-031 SHALL cover: mode=11 entered at phase P2, ramp=7 for 100 clocks -> phase/ramp unchanged and B duty=7 every period; on return to 00, ramp resumes at 8.
REQ-032 SHALL cover: macro on, mode=01, static R=15, brightness=7 -> R duty=(15*8)>>4=7.
REQ-033 SHALL cover: mode changed 01->10 at pwm_cnt=3 -> the current period completes unchanged, and led goes dark from the next period start.

Source files
------------

// File: rtl/rainbow_pwm.sv
// Three-channel PWM LED driver with a six-phase hue ramp (rainbow), static, off and freeze modes.
// Optional global brightness scaling is enabled by defining RAINBOW_PWM_BRIGHTNESS_EN.

module rainbow_pwm_ch #(
   parameter int PWM_BITS   = 8,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PWM_BITS-1:0] i_colour,
   input  logic [PWM_BITS-1:0] i_bright,
   input  logic                i_load,
   input  logic [PWM_BITS-1:0] i_cnt,
   output logic                o_led
);
   logic [PWM_BITS-1:0] w_duty;
   logic [PWM_BITS-1:0] r_duty;
   logic                r_led;

`ifdef RAINBOW_PWM_BRIGHTNESS_EN
   // (c * (brightness+1)) >> PWM_BITS; the result never exceeds c, so PWM_BITS bits suffice
   logic [PWM_BITS:0]     w_bp1;
   logic [2*PWM_BITS:0]   w_prod;
   logic                  w_unused_prod;
   assign w_bp1         = {1'b0, i_bright} + {{PWM_BITS{1'b0}}, 1'b1};
   assign w_prod        = {{(PWM_BITS+1){1'b0}}, i_colour} * {{PWM_BITS{1'b0}}, w_bp1};
   assign w_duty        = w_prod[2*PWM_BITS-1:PWM_BITS];
   assign w_unused_prod = ^{w_prod[2*PWM_BITS], w_prod[PWM_BITS-1:0]};
`else
   logic w_unused_bright;
   assign w_duty          = i_colour;
   assign w_unused_bright = ^i_bright;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_duty <= '0;
         r_led  <= ACTIVE_LOW;
      end else begin
         if (i_load) r_duty <= w_duty;
         r_led <= (i_cnt < r_duty) ^ ACTIVE_LOW;
      end
   end

   assign o_led = r_led;
endmodule

module rainbow_pwm #(
   parameter int PWM_BITS   = 8,
   parameter int STEP_DIV   = 1024,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            mode,
   input  logic [3*PWM_BITS-1:0] static_rgb,
   input  logic [PWM_BITS-1:0]   brightness,
   output logic [2:0]            led
);
   localparam int MAX   = (1 << PWM_BITS) - 1;
   localparam int RW    = (PWM_BITS > 8) ? PWM_BITS : 8;
   localparam int PSW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam bit AL    = (ACTIVE_LOW != 0);
   localparam int NCH   = 3;

   typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5} phase_t;

   logic [PWM_BITS-1:0]          r_cnt;
   logic [PSW-1:0]               r_presc;
   phase_t                       r_phase;
   logic [RW-1:0]                r_ramp;
   logic                         w_wrap;
   logic                         w_run;
   logic                         w_tick;
   logic [PWM_BITS-1:0]          w_rmp;
   logic [PWM_BITS-1:0]          w_inv;
   logic [NCH-1:0][PWM_BITS-1:0] w_hue;
   logic [NCH-1:0][PWM_BITS-1:0] w_col;
   logic [NCH-1:0]               w_led;

   assign w_wrap = (r_cnt == PWM_BITS'(MAX - 1));
   assign w_run  = (mode == 2'b00);
   assign w_tick = w_run && (r_presc == PSW'(STEP_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)      r_cnt <= '0;
      else if (w_wrap) r_cnt <= '0;
      else             r_cnt <= r_cnt + 1'b1;
   end

   // prescaler only advances in rainbow mode; all other modes hold it
   always_ff @(posedge clk) begin
      if (!rst_n)      r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else if (w_run)  r_presc <= r_presc + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_phase <= P0;
         r_ramp  <= '0;
      end else if (w_tick) begin
         if (r_ramp < RW'(MAX)) begin
            r_ramp <= r_ramp + 1'b1;
         end else begin
            r_ramp <= '0;
            case (r_phase)
               P0:      r_phase <= P1;
               P1:      r_phase <= P2;
               P2:      r_phase <= P3;
               P3:      r_phase <= P4;
               P4:      r_phase <= P5;
               default: r_phase <= P0;
            endcase
         end
      end
   end

   // ramp never exceeds MAX, so its upper bits carry no colour information
   logic w_unused_ramp;
   generate
      if (RW > PWM_BITS) begin : g_ramp_hi
         assign w_unused_ramp = ^r_ramp[RW-1:PWM_BITS];
      end else begin : g_ramp_eq
         assign w_unused_ramp = 1'b0;
      end
   endgenerate

   assign w_rmp = r_ramp[PWM_BITS-1:0];
   assign w_inv = PWM_BITS'(MAX) - w_rmp;

   // lane 0 = R, 1 = G, 2 = B
   always_comb begin
      w_hue = '0;
      case (r_phase)
         P0:      begin w_hue[0] = PWM_BITS'(MAX); w_hue[1] = w_rmp;          w_hue[2] = '0;             end
         P1:      begin w_hue[0] = w_inv;          w_hue[1] = PWM_BITS'(MAX); w_hue[2] = '0;             end
         P2:      begin w_hue[0] = '0;             w_hue[1] = PWM_BITS'(MAX); w_hue[2] = w_rmp;          end
         P3:      begin w_hue[0] = '0;             w_hue[1] = w_inv;          w_hue[2] = PWM_BITS'(MAX); end
         P4:      begin w_hue[0] = w_rmp;          w_hue[1] = '0;             w_hue[2] = PWM_BITS'(MAX); end
         P5:      begin w_hue[0] = PWM_BITS'(MAX); w_hue[1] = '0;             w_hue[2] = w_inv;          end
         default: w_hue = '0;
      endcase
   end

   always_comb begin
      w_col = '0;
      case (mode)
         2'b01: begin
            for (int i = 0; i < NCH; i++)
               w_col[i] = static_rgb[(NCH-1-i)*PWM_BITS +: PWM_BITS];
         end
         2'b10:   w_col = '0;
         default: w_col = w_hue;
      endcase
   end

   generate
      for (genvar g = 0; g < NCH; g++) begin : g_ch
         rainbow_pwm_ch #(
            .PWM_BITS   (PWM_BITS),
            .ACTIVE_LOW (AL)
         ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_colour (w_col[g]),
            .i_bright (brightness),
            .i_load   (w_wrap),
            .i_cnt    (r_cnt),
            .o_led    (w_led[g])
         );
      end
   endgenerate

   assign led = w_led;
endmodule

// File: tb/tb_rainbow_pwm.sv
// Directed bench for rainbow_pwm at PWM_BITS=4, STEP_DIV=2, ACTIVE_LOW=1.
module tb_rainbow_pwm;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [11:0] static_rgb = '0;
   logic [3:0]  brightness = '0;
   logic [2:0]  led;

   int n_chk = 0;
   int n_err = 0;
   int lr, lg, lb;

   rainbow_pwm #(.PWM_BITS(4), .STEP_DIV(2), .ACTIVE_LOW(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .static_rgb (static_rgb),
      .brightness (brightness),
      .led        (led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cnt(input int v);
      int k = 0;
      while (int'(dut.r_cnt) != v && k < 20) begin
         tick(1);
         k++;
      end
      if (int'(dut.r_cnt) != v) chk("align", int'(dut.r_cnt), v);
   endtask

   // count lit (pin low) samples per channel over one full period
   task automatic measure(output int r, output int g, output int b);
      r = 0; g = 0; b = 0;
      wait_cnt(1);
      for (int i = 0; i < 15; i++) begin
         r += int'(!led[0]);
         g += int'(!led[1]);
         b += int'(!led[2]);
         tick(1);
      end
   endtask

   task automatic do_reset(input logic [1:0] m);
      rst_n = 1'b0;
      mode  = m;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("rst_led", int'(led), 7);
      end
      chk("rst_phase", int'(dut.r_phase), 0);
      chk("rst_ramp", int'(dut.r_ramp), 0);
      rst_n = 1'b1;
   endtask

   initial begin
      int er, eb, sr, sb;
      // rainbow from reset: dark first period, then P0 colour, phase timing
      do_reset(2'b00);
      measure(lr, lg, lb);
      chk("p1_dark", lr + lg + lb, 0);
      measure(lr, lg, lb);
      chk("p0_r", lr, 15);
      chk("p0_g", lg, 7);
      chk("p0_b", lb, 0);
      chk("ramp31", int'(dut.r_ramp), 15);
      chk("phase31", int'(dut.r_phase), 0);
      tick(1);
      chk("phase32", int'(dut.r_phase), 1);
      chk("ramp32", int'(dut.r_ramp), 0);
      tick(160);
      chk("phase192", int'(dut.r_phase), 0);
      chk("ramp192", int'(dut.r_ramp), 0);

      // freeze at P2 ramp 7
      do_reset(2'b00);
      tick(78);
      chk("pre_frz_phase", int'(dut.r_phase), 2);
      chk("pre_frz_ramp", int'(dut.r_ramp), 7);
      mode = 2'b11;
      tick(100);
      chk("frz_phase", int'(dut.r_phase), 2);
      chk("frz_ramp", int'(dut.r_ramp), 7);
      measure(lr, lg, lb);
      chk("frz_r", lr, 0);
      chk("frz_g", lg, 15);
      chk("frz_b", lb, 7);
      chk("frz_ramp2", int'(dut.r_ramp), 7);
      mode = 2'b00;
      tick(1);
      chk("resume_ramp1", int'(dut.r_ramp), 7);
      tick(1);
      chk("resume_ramp2", int'(dut.r_ramp), 8);

      // static colour, brightness 7
      static_rgb = {4'd15, 4'd0, 4'd5};
      brightness = 4'd7;
`ifdef RAINBOW_PWM_BRIGHTNESS_EN
      er = 7; eb = 2;
`else
      er = 15; eb = 5;
`endif
      do_reset(2'b01);
      measure(lr, lg, lb);
      chk("st_dark", lr + lg + lb, 0);
      measure(lr, lg, lb);
      chk("st_r", lr, er);
      chk("st_g", lg, 0);
      chk("st_b", lb, eb);

      // 01 -> 10 at pwm_cnt 3: remainder of period unchanged, then dark
      wait_cnt(3);
      mode = 2'b10;
      sr = 0; sb = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         sr += int'(!led[0]);
         sb += int'(!led[2]);
      end
      chk("tail_r", sr, (er > 3) ? er - 3 : 0);
      chk("tail_b", sb, (eb > 3) ? eb - 3 : 0);
      measure(lr, lg, lb);
      chk("off_lit", lr + lg + lb, 0);
      chk("off_ramp", int'(dut.r_ramp), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
